branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the pipeline's PC-source decoder.
- Resolves control transfers in EX and adds BLTU/BGEU support.
- Adds a BHT of 2-bit saturating counters, queried in ID, that gives a taken/not-taken prediction.
- Generates PC select, pipeline flush and saturating performance counters; sits between the ID/EX pipeline registers and the PC mux.

Parameters:
- XLEN, 32, address width of id_pc/ex_pc.
- BHT_ENTRIES, 16, number of BHT counters; power of two, minimum 2.
- IDX_W, $clog2(BHT_ENTRIES), derived index width; do not override.
- CNT_W, 16, width of each performance counter.
- ENABLE_PRED, 1, 0 = predictor disabled (id_pred_taken tied 0, no BHT updates, predict-not-taken semantics).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- id_pc  in  XLEN  PC of instruction in ID (BHT lookup).
- id_pred_taken  out  1  prediction for id_pc.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_branch  in  1  conditional branch in EX.
- ex_jal  in  1  JAL in EX.
- ex_jalr  in  1  JALR in EX.
- ex_func3  in  3  branch func3.
- ex_zero  in  1  ALU result zero (rs1 == rs2).
- ex_lt  in  1  signed rs1 < rs2.
- ex_ltu  in  1  unsigned rs1 < rs2.
- ex_pc  in  XLEN  PC of EX instruction (BHT update index).
- ex_pred_taken  in  1  prediction carried down with the EX instruction.
- pc_src  out  2  00 sequential, 01 EX target (pc+imm), 10 JALR target, 11 recovery (ex_pc+4).
- flush  out  1  squash IF/ID and ID/EX.
- branch_cnt  out  CNT_W  resolved conditional branches.
- mispred_cnt  out  CNT_W  branch mispredictions.

Behaviour:
- BHT index = pc[IDX_W+1:2]. Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST. id_pred_taken = counter[1] (combinational read).
- Reset (async, rst_n=0): all counters = 01 (WNT); branch_cnt = mispred_cnt = 0. Combinational outputs follow their inputs during reset.
- Branch outcome "taken":
  - func3 000 BEQ: zero. 001 BNE: !zero.
  - 100 BLT: lt. 101 BGE: !lt.
  - 110 BLTU: ltu. 111 BGEU: !ltu.
  - 010/011: not taken, never counted as mispredict, no BHT update, branch_cnt not incremented.
- pc_src / flush are combinational, zero latency, with priority ex_valid=0 > jal > jalr > branch:
  - ex_valid=0: pc_src=00, flush=0.
  - jal: 01. jalr: 10 (both override branch if asserted together).
  - branch, taken, ex_pred_taken=0: 01.
  - branch, not taken, ex_pred_taken=1: 11.
  - branch, prediction correct: 00 (ID already redirected on predicted-taken).
  - otherwise: 00.
  - flush = (pc_src != 00).
- Clocked updates, on a rising edge with ex_valid & ex_branch & legal func3:
  - Counter at ex_pc index: +1 if taken, -1 if not; saturates at 11/00.
  - branch_cnt +1.
  - mispred_cnt +1 if taken != ex_pred_taken.
  - Both counters saturate at 2^CNT_W-1; no wrap.
- Same-cycle read/write of the same index: id_pred_taken returns the pre-update value (no bypass).
- ENABLE_PRED=0: treat ex_pred_taken as 0; BHT removed; counters still operate; pc_src 11 never produced.
- Reset mid-operation: state clears immediately; no partial counter updates.

Decomposition:
- Shared package branch_pkg holds:
  - func3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - PC_SEQ/PC_TGT/PC_JALR/PC_RECOV encodings.
  - BHT state constants SNT/WNT/WT/ST.
- One sub-module: bht_2bit (BHT_ENTRIES, IDX_W): combinational read port, one synchronous update port, async active-low reset.
- Resolve logic and counters stay in the top.

Test Plan:
- Reset then id_pc=0x0 -> id_pred_taken=0; all counters 0.
- BEQ at ex_pc=0x40, zero=1, pred=0 -> pc_src=01, flush=1. Repeat twice -> counter reaches ST, id_pred_taken(0x40)=1, mispred_cnt=2, branch_cnt=3.
- BLTU with ltu=1, lt=0, pred=1 -> pc_src=00, flush=0, no mispred increment. Then BGEU, ltu=1, pred=1 -> pc_src=11, flush=1.
- jal and jalr both high with branch taken -> pc_src=01. jalr only -> 10. ex_valid=0 with jal=1 -> 00, no counter change.
- CNT_W=4: 20 mispredicting branches -> mispred_cnt holds 15. func3=010 -> pc_src=00, counts unchanged.
- Assert rst_n low mid-stream (asynchronously between edges) -> counters/BHT cleared immediately. Separately, an update and an ID lookup of the same index in one cycle -> lookup returns the old value. With ENABLE_PRED=0, a not-taken branch with ex_pred_taken=1 -> pc_src=00.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants for branch resolution: func3 codes, PC-select encodings,
// 2-bit BHT counter states and the saturating counter step function.
package branch_pkg;

    // Conditional-branch func3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // PC mux select encodings
    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_TGT   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;
    localparam logic [1:0] PC_RECOV = 2'b11;

    // 2-bit saturating predictor states; bit 1 is the taken prediction
    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    // Move a predictor state one step toward the observed outcome
    function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        nxt = state;
        if (taken) begin
            if (state != BHT_ST) nxt = state + 2'd1;
        end else begin
            if (state != BHT_SNT) nxt = state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters. One combinational read
// port (ID lookup) and one synchronous update port (EX resolution). A read of
// an entry being updated in the same cycle returns the old value.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [1:0]       o_rdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic             i_taken
);

    logic [1:0] w_bht [BHT_ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
            logic [1:0] r_state;

            // Per-entry counter: cleared to weakly-not-taken, stepped on a matching update
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= BHT_WNT;
                end else if (i_we && (i_widx == IDX_W'(gi))) begin
                    r_state <= bht_next(r_state, i_taken);
                end
            end

            assign w_bht[gi] = r_state;
        end
    endgenerate

    assign o_rdata = w_bht[i_ridx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage control transfers into a PC-mux select and pipeline
// flush, hosts the optional 2-bit branch predictor queried from ID, and keeps
// saturating counts of resolved branches and mispredictions.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES),
    parameter int CNT_W       = 16,
    parameter bit ENABLE_PRED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_func3,
    input  logic            ex_zero,
    input  logic            ex_lt,
    input  logic            ex_ltu,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    output logic [1:0]      pc_src,
    output logic            flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic             w_taken;
    logic             w_legal;
    logic             w_pred;
    logic             w_update;
    logic             w_mispred;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             w_unused_pc;

    // Evaluate the branch condition; func3 010/011 are not branches
    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        case (ex_func3)
            F3_BEQ:  w_taken = ex_zero;
            F3_BNE:  w_taken = !ex_zero;
            F3_BLT:  w_taken = ex_lt;
            F3_BGE:  w_taken = !ex_lt;
            F3_BLTU: w_taken = ex_ltu;
            F3_BGEU: w_taken = !ex_ltu;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_update  = ex_valid && ex_branch && w_legal;
    assign w_mispred = (w_taken != w_pred);

    genvar gi;
    generate
        if (ENABLE_PRED) begin : g_pred
            logic [1:0] w_rd;
            logic       w_unused_rd;

            bht_2bit #(
                .BHT_ENTRIES (BHT_ENTRIES),
                .IDX_W       (IDX_W)
            ) u_bht (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_ridx  (id_pc[IDX_W+1:2]),
                .o_rdata (w_rd),
                .i_we    (w_update),
                .i_widx  (ex_pc[IDX_W+1:2]),
                .i_taken (w_taken)
            );

            assign id_pred_taken = w_rd[1];
            assign w_pred        = ex_pred_taken;
            assign w_unused_rd   = w_rd[0];
        end else begin : g_nopred
            // Predict-not-taken: the carried prediction is ignored entirely
            assign id_pred_taken = 1'b0;
            assign w_pred        = 1'b0;
        end
    endgenerate

    // Only the index bits of the PCs matter here
    assign w_unused_pc = ^{id_pc, ex_pc, ex_pred_taken};

    // PC select priority: bubble, JAL, JALR, then conditional branch
    always_comb begin
        pc_src = PC_SEQ;
        if (ex_valid) begin
            if (ex_jal) begin
                pc_src = PC_TGT;
            end else if (ex_jalr) begin
                pc_src = PC_JALR;
            end else if (ex_branch && w_legal) begin
                if (w_taken && !w_pred) begin
                    pc_src = PC_TGT;
                end else if (!w_taken && w_pred) begin
                    pc_src = PC_RECOV;
                end
            end
        end
    end

    assign flush = (pc_src != PC_SEQ);

    // Saturating performance counters, stepped once per resolved branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_update) begin
            if (r_branch_cnt != {CNT_W{1'b1}}) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a predicting instance with 4-bit counters and
// a predictor-disabled instance share stimulus; expectations come from a
// behavioural model and are queued per transaction.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_pc = '0;
    logic        ex_valid = 1'b0;
    logic        ex_branch = 1'b0;
    logic        ex_jal = 1'b0;
    logic        ex_jalr = 1'b0;
    logic [2:0]  ex_func3 = '0;
    logic        ex_zero = 1'b0;
    logic        ex_lt = 1'b0;
    logic        ex_ltu = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_pred_taken = 1'b0;

    logic        id_pred_taken, flush, id_pred_np, flush_np;
    logic [1:0]  pc_src, pc_src_np;
    logic [3:0]  branch_cnt, mispred_cnt;
    logic [15:0] branch_cnt_np, mispred_cnt_np;

    always #5 clk = ~clk;

    branch_resolve_unit #(.CNT_W(4), .ENABLE_PRED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_func3(ex_func3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .pc_src(pc_src), .flush(flush),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_unit #(.CNT_W(16), .ENABLE_PRED(1'b0)) u_dut_np (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_pred_taken(id_pred_np),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_func3(ex_func3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .pc_src(pc_src_np), .flush(flush_np),
        .branch_cnt(branch_cnt_np), .mispred_cnt(mispred_cnt_np)
    );

    typedef struct {
        logic [1:0] pc;
        logic       fl;
        logic       idp;
        logic [1:0] pc_np;
        logic       fl_np;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_bht[16];
    int   m_br, m_mis, m_br_np, m_mis_np;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_taken(input bit [2:0] f3, input bit z, input bit l, input bit lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_src(input bit v, input bit br, input bit j, input bit jr,
                                         input bit legal, input bit tk, input bit pr);
        if (!v) return 2'b00;
        if (j) return 2'b01;
        if (jr) return 2'b10;
        if (br && legal) begin
            if (tk && !pr) return 2'b01;
            if (!tk && pr) return 2'b11;
        end
        return 2'b00;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_br = 0; m_mis = 0; m_br_np = 0; m_mis_np = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(m_br));
        check({tag, "_mispred_cnt"}, 32'(mispred_cnt), 32'(m_mis));
        check({tag, "_branch_cnt_np"}, 32'(branch_cnt_np), 32'(m_br_np));
        check({tag, "_mispred_cnt_np"}, 32'(mispred_cnt_np), 32'(m_mis_np));
    endtask

    // One EX transaction: drive, check combinational outputs, clock, check state
    task automatic tx(input string tag, input bit v, input bit br, input bit j, input bit jr,
                      input bit [2:0] f3, input bit z, input bit l, input bit lu,
                      input logic [31:0] epc, input bit pr, input logic [31:0] ipc);
        exp_t e;
        bit   tk, legal, upd;
        int   idx;
        @(negedge clk);
        ex_valid = v; ex_branch = br; ex_jal = j; ex_jalr = jr; ex_func3 = f3;
        ex_zero = z; ex_lt = l; ex_ltu = lu; ex_pc = epc; ex_pred_taken = pr; id_pc = ipc;
        tk    = m_taken(f3, z, l, lu);
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        upd   = v && br && legal;
        e.pc    = m_src(v, br, j, jr, legal, tk, pr);
        e.fl    = (e.pc != 2'b00);
        e.pc_np = m_src(v, br, j, jr, legal, tk, 1'b0);
        e.fl_np = (e.pc_np != 2'b00);
        e.idp   = (m_bht[ipc[5:2]] >= 2);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check({tag, "_pc_src"}, 32'(pc_src), 32'(e.pc));
        check({tag, "_flush"}, 32'(flush), 32'(e.fl));
        check({tag, "_id_pred"}, 32'(id_pred_taken), 32'(e.idp));
        check({tag, "_pc_src_np"}, 32'(pc_src_np), 32'(e.pc_np));
        check({tag, "_flush_np"}, 32'(flush_np), 32'(e.fl_np));
        check({tag, "_id_pred_np"}, 32'(id_pred_np), 32'd0);
        @(posedge clk);
        if (upd) begin
            idx = epc[5:2];
            if (tk && m_bht[idx] < 3) m_bht[idx]++;
            if (!tk && m_bht[idx] > 0) m_bht[idx]--;
            if (m_br < 15) m_br++;
            if ((tk != pr) && m_mis < 15) m_mis++;
            if (m_br_np < 65535) m_br_np++;
            if (tk && m_mis_np < 65535) m_mis_np++;
        end
        #1;
        check_counts(tag);
        check({tag, "_id_pred_post"}, 32'(id_pred_taken), 32'(m_bht[ipc[5:2]] >= 2));
        $display("tx %s v=%0b br=%0b jal=%0b jalr=%0b f3=%0d ex_pc=%0h pred=%0b pc_src=%0d flush=%0b bcnt=%0d mcnt=%0d",
                 tag, v, br, j, jr, f3, epc, pr, pc_src, flush, branch_cnt, mispred_cnt);
    endtask

    initial begin
        m_reset();
        #2;
        check("reset_id_pred", 32'(id_pred_taken), 32'd0);
        check_counts("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Train BEQ at 0x40 to strongly taken
        tx("beq1", 1, 1, 0, 0, 3'd0, 1, 0, 0, 32'h40, 0, 32'h40);
        tx("beq2", 1, 1, 0, 0, 3'd0, 1, 0, 0, 32'h40, 0, 32'h40);
        tx("beq3", 1, 1, 0, 0, 3'd0, 1, 0, 0, 32'h40, 1, 32'h40);

        // Unsigned compares
        tx("bltu", 1, 1, 0, 0, 3'd6, 0, 0, 1, 32'h84, 1, 32'h40);
        tx("bgeu", 1, 1, 0, 0, 3'd7, 0, 0, 1, 32'h84, 1, 32'h40);
        tx("blt", 1, 1, 0, 0, 3'd4, 0, 1, 0, 32'h88, 0, 32'h88);
        tx("bge", 1, 1, 0, 0, 3'd5, 0, 1, 0, 32'h88, 1, 32'h88);

        // Jump priority and bubbles
        tx("jal_jalr_br", 1, 1, 1, 1, 3'd0, 1, 0, 0, 32'h90, 0, 32'h90);
        tx("jalr_only", 1, 0, 0, 1, 3'd0, 0, 0, 0, 32'h90, 0, 32'h90);
        tx("bubble_jal", 0, 1, 1, 0, 3'd0, 1, 0, 0, 32'h90, 0, 32'h90);

        // Counter saturation at 4 bits
        for (int i = 0; i < 20; i++)
            tx("sat", 1, 1, 0, 0, 3'd1, 0, 0, 0, 32'h100 + 32'(i * 4), 0, 32'h40);
        tx("f3_010", 1, 1, 0, 0, 3'd2, 1, 1, 1, 32'h40, 0, 32'h40);
        tx("f3_011", 1, 1, 0, 0, 3'd3, 0, 0, 0, 32'h40, 1, 32'h40);

        // Same-index read during update returns the pre-update state
        tx("same_idx_t", 1, 1, 0, 0, 3'd0, 1, 0, 0, 32'h1C, 0, 32'h1C);
        tx("same_idx_nt", 1, 1, 0, 0, 3'd0, 0, 0, 0, 32'h1C, 1, 32'h1C);

        // Predicted-taken branch that falls through: recovery vs disabled predictor
        tx("np_recov", 1, 1, 0, 0, 3'd1, 1, 0, 0, 32'h2C, 1, 32'h2C);

        // Asynchronous reset between edges
        @(negedge clk);
        ex_valid = 1'b0;
        id_pc = 32'h40;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_id_pred", 32'(id_pred_taken), 32'd0);
        check_counts("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            tx("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 7) * 4),
               1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 7) * 4));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
